// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch key front end and count-control FSM; optional lap feature under STOPWATCH_LAP_EN

// One key: two-flop synchronizer, debouncer and single-cycle press pulse.
// The pulse is only allowed once the key has been seen released after reset.
module stopwatch_key #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic ready,
    output logic pulse
);
    localparam int            CW   = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic          armed;
    logic [CW-1:0] cnt;

    // two-flop synchronizer for the asynchronous raw key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // accept a new level only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // arm once a genuine released sample is seen, then pulse on each debounced 1->0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b1;
            armed   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            if (ready && sync2) begin
                armed <= 1'b1;
            end
            pulse <= armed && level_d && !level;
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_n,
    input  logic       btn_clear_n,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap_n,
    output logic       lap_hold,
`endif
    output logic [1:0] cnt_ctrl
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] ready_sr;
    logic       ready;
    logic       start_pulse;
    logic       clear_pulse;

    // synchronizer outputs are reset values for two edges after reset; ready marks real samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_sr <= 2'b00;
        end else begin
            ready_sr <= {ready_sr[0], 1'b1};
        end
    end

    assign ready = ready_sr[1];

    stopwatch_key #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (btn_start_n),
        .ready (ready),
        .pulse (start_pulse)
    );

    stopwatch_key #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (btn_clear_n),
        .ready (ready),
        .pulse (clear_pulse)
    );

    // state register; it drives the counter command bus directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state: start wins in IDLE/COUNT, clear wins in PAUSE, 2'b11 recovers to IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_pulse) state_next = S_COUNT;
            end
            S_COUNT: begin
                if (start_pulse) state_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (clear_pulse)      state_next = S_IDLE;
                else if (start_pulse) state_next = S_COUNT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign cnt_ctrl = state;

`ifdef STOPWATCH_LAP_EN
    logic lap_pulse;
    logic lap_next;

    stopwatch_key #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (btn_lap_n),
        .ready (ready),
        .pulse (lap_pulse)
    );

    // lap toggles the display freeze while counting; entering IDLE always unfreezes
    always_comb begin
        lap_next = lap_hold;
        if (state_next == S_IDLE) begin
            lap_next = 1'b0;
        end else if (state == S_COUNT && lap_pulse) begin
            lap_next = ~lap_hold;
        end
    end

    // lap_hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_hold <= 1'b0;
        end else begin
            lap_hold <= lap_next;
        end
    end
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with DEB_CYCLES=4
module tb_stopwatch_ctrl;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start_n = 1'b1;
    logic       btn_clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
    logic       btn_lap_n = 1'b1;
    logic       lap_hold;
    logic       lap_q[$];
`endif
    logic [1:0] cnt_ctrl;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];
    int         chg_cnt = 0;
    logic [1:0] prev_ctrl = 2'b00;

    always #10 clk = ~clk;

    stopwatch_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_start_n (btn_start_n),
        .btn_clear_n (btn_clear_n),
`ifdef STOPWATCH_LAP_EN
        .btn_lap_n   (btn_lap_n),
        .lap_hold    (lap_hold),
`endif
        .cnt_ctrl    (cnt_ctrl)
    );

    always @(negedge clk) begin
        if (cnt_ctrl !== prev_ctrl) chg_cnt++;
        prev_ctrl = cnt_ctrl;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick(1);
        btn_start_n = 1'b1;
        btn_clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
        btn_lap_n = 1'b1;
`endif
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic press(input logic s, input logic c);
        if (s) btn_start_n = 1'b0;
        if (c) btn_clear_n = 1'b0;
        tick(12);
        btn_start_n = 1'b1;
        btn_clear_n = 1'b1;
        tick(12);
    endtask

    task automatic test_reset;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt_ctrl !== 2'b00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00", cnt_ctrl);
        end
`ifdef STOPWATCH_LAP_EN
        checks++;
        if (lap_hold !== 1'b0) begin
            failures++;
            $display("FAIL reset_lap got=%b exp=0", lap_hold);
        end
`endif
        tick(3);
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_bounce;
        int c0;
        c0 = chg_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_start_n = ~btn_start_n;
            tick(3);
        end
        btn_start_n = 1'b1;
        tick(20);
        checks++;
        if (cnt_ctrl !== 2'b00) begin
            failures++;
            $display("FAIL bounce_ctrl got=%b exp=00", cnt_ctrl);
        end
        checks++;
        if (chg_cnt != c0) begin
            failures++;
            $display("FAIL bounce_changes got=%0d exp=0", chg_cnt - c0);
        end
    endtask

    task automatic test_first_press;
        int         c0;
        logic [1:0] e;
        do_reset();
        c0 = chg_cnt;
        exp_q.push_back(2'b01);
        btn_start_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 7) begin
                checks++;
                if (cnt_ctrl !== 2'b00) begin
                    failures++;
                    $display("FAIL first_press_early got=%b exp=00", cnt_ctrl);
                end
            end
            if (i == 8) begin
                e = exp_q.pop_front();
                checks++;
                if (cnt_ctrl !== e) begin
                    failures++;
                    $display("FAIL first_press_latency got=%b exp=%b", cnt_ctrl, e);
                end
            end
        end
        repeat (12) @(posedge clk);
        #1;
        btn_start_n = 1'b1;
        tick(12);
        checks++;
        if (cnt_ctrl !== 2'b01 || chg_cnt - c0 != 1) begin
            failures++;
            $display("FAIL first_press_single got=%b changes=%0d exp=01 changes=1", cnt_ctrl, chg_cnt - c0);
        end
    endtask

    task automatic test_full_cycle;
        logic       s_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       c_tab[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0] e_tab[5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [1:0] e;
        int         c0;
        do_reset();
        c0 = chg_cnt;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(e_tab[i]);
            press(s_tab[i], c_tab[i]);
            e = exp_q.pop_front();
            checks++;
            if (cnt_ctrl !== e) begin
                failures++;
                $display("FAIL full_cycle_step%0d got=%b exp=%b", i, cnt_ctrl, e);
            end
        end
        checks++;
        if (chg_cnt - c0 != 5) begin
            failures++;
            $display("FAIL full_cycle_changes got=%0d exp=5", chg_cnt - c0);
        end
    endtask

    task automatic test_clear_simul;
        logic       s_tab[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       c_tab[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] e_tab[6] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
        logic [1:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(e_tab[i]);
            press(s_tab[i], c_tab[i]);
            e = exp_q.pop_front();
            checks++;
            if (cnt_ctrl !== e) begin
                failures++;
                $display("FAIL clear_simul_step%0d got=%b exp=%b", i, cnt_ctrl, e);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [1:0] e;
        int         c0;
        do_reset();
        exp_q.push_back(2'b01);
        press(1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (cnt_ctrl !== e) begin
            failures++;
            $display("FAIL async_pre got=%b exp=%b", cnt_ctrl, e);
        end
        btn_start_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt_ctrl !== 2'b00) begin
            failures++;
            $display("FAIL async_immediate got=%b exp=00", cnt_ctrl);
        end
        #2;
        rst_n = 1'b1;
        tick(1);
        c0 = chg_cnt;
        tick(30);
        checks++;
        if (cnt_ctrl !== 2'b00 || chg_cnt != c0) begin
            failures++;
            $display("FAIL async_held_key got=%b changes=%0d exp=00 changes=0", cnt_ctrl, chg_cnt - c0);
        end
        btn_start_n = 1'b1;
        tick(12);
        exp_q.push_back(2'b01);
        press(1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (cnt_ctrl !== e) begin
            failures++;
            $display("FAIL async_repress got=%b exp=%b", cnt_ctrl, e);
        end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap;
        logic       k_tab[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       s_tab[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       c_tab[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0] e_tab[7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
        logic       h_tab[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] e;
        logic       h;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(e_tab[i]);
            lap_q.push_back(h_tab[i]);
            if (k_tab[i]) begin
                btn_lap_n = 1'b0;
                tick(12);
                btn_lap_n = 1'b1;
                tick(12);
            end else begin
                press(s_tab[i], c_tab[i]);
            end
            e = exp_q.pop_front();
            h = lap_q.pop_front();
            checks++;
            if (cnt_ctrl !== e || lap_hold !== h) begin
                failures++;
                $display("FAIL lap_step%0d got=%b/%b exp=%b/%b", i, cnt_ctrl, lap_hold, e, h);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bounce();
        test_first_press();
        test_full_cycle();
        test_clear_simul();
        test_async_reset();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch control front end. It debounces the raw push-buttons, turns each press into a single-cycle event, and runs a Moore state machine. The machine drives the 2-bit `cnt_ctrl` command bus consumed by the stopwatch time counter. It sits between the board keys and the time counter, on the same 50 MHz clock.

## Interface
- `DEB_CYCLES`, default 1000000, number of consecutive stable clock cycles required to accept a button level change (20 ms at 50 MHz); legal range 2..2^24.
- `clk`  input  1  system clock, 50 MHz; one clock domain, all logic on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `btn_start_n`  input  1  raw start/pause key, active-low, asynchronous to `clk`.
- `btn_clear_n`  input  1  raw clear key, active-low, asynchronous to `clk`.
- `btn_lap_n`  input  1  raw lap key, active-low; present only with `STOPWATCH_LAP_EN`.
- `cnt_ctrl`  output  2  counter command: 2'b00 IDLE (hold at zero), 2'b01 COUNT, 2'b10 PAUSE; registered state.
- `lap_hold`  output  1  display freeze request; present only with `STOPWATCH_LAP_EN`.

## Operation
- Each raw key passes through a two-flop synchronizer, then an independent debouncer:
  - The debounced level starts at released (1).
  - The debounce counter (width ceil(log2(DEB_CYCLES))) increments on every edge where the synchronized level differs from the debounced level.
  - Any edge with equal levels clears the counter.
  - When the counter would reach DEB_CYCLES, the debounced level takes the synchronized value and the counter clears.
- Press pulse: registered, high for exactly one cycle after the debounced level goes 1->0. Releases generate nothing.
- State machine (state register drives `cnt_ctrl` directly):
  - IDLE: start pulse -> COUNT; clear pulse -> IDLE (no-op).
  - COUNT: start pulse -> PAUSE; clear pulse ignored.
  - PAUSE: clear pulse -> IDLE; otherwise start pulse -> COUNT.
  - Encoding 2'b11 is illegal and returns to IDLE on the next edge.
- Simultaneous start and clear pulses in the same cycle:
  - In PAUSE, clear wins -> IDLE.
  - In IDLE or COUNT, start wins.
- Held keys produce one pulse only. Bounce shorter than DEB_CYCLES produces no pulse.

## Timing
- Reset values:
  - `cnt_ctrl` = 2'b00.
  - `lap_hold` = 0.
  - Synchronizers and debounced levels = 1.
  - Debounce counters = 0.
  - Pulses = 0.
- Reset asserted mid-operation forces all of the above immediately, with no dependence on `clk`. A key held through reset release must first be seen released, then pressed again, before it generates a pulse.
- Latency: let raw key low be captured by the first synchronizer flop at edge N and held stable from then on:
  - debounced level falls at edge N+DEB_CYCLES+1;
  - the press pulse is high after edge N+DEB_CYCLES+2;
  - `cnt_ctrl` changes at edge N+DEB_CYCLES+3.
- `cnt_ctrl` changes only on clock edges and is glitch-free. The time counter samples it directly.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - Adds `btn_lap_n`, its synchronizer and debouncer, and `lap_hold`.
  - A lap pulse in COUNT toggles `lap_hold`.
  - A lap pulse in IDLE or PAUSE is ignored.
  - Any transition into IDLE clears `lap_hold` on the same edge.
  - `cnt_ctrl` behaviour is unchanged, so counting continues while the display is frozen.
- `STOPWATCH_LAP_EN` undefined: the ports and all lap logic are absent, and the state machine is identical.

## Test plan
- Run with DEB_CYCLES=4.
- Reset and first press: assert `rst_n` low, release it, then drive a clean start press held 20 cycles -> `cnt_ctrl` 00 until edge N+7, then 01. Exactly one pulse is generated.
- Bounce rejection: toggle `btn_start_n` every 3 cycles for 30 cycles, then hold high -> `cnt_ctrl` stays 00 and no pulse is generated.
- Full cycle: presses start, start, start, start, clear, each separated by 20 cycles -> `cnt_ctrl` sequence 01, 10, 01, 10, 00.
- Clear ignored in COUNT, plus simultaneous keys:
  - In COUNT, press clear -> `cnt_ctrl` stays 01.
  - In PAUSE, press start and clear in the same cycle -> 00.
  - In COUNT, press both in the same cycle -> 10.
- Async reset mid-debounce: in COUNT, hold the start key low for 2 cycles, then pulse `rst_n` low between clock edges -> `cnt_ctrl` = 00 immediately. The held key produces no pulse after reset until it is released and pressed again.
- Lap, with `STOPWATCH_LAP_EN`:
  - In COUNT, lap press -> `lap_hold` 1; second lap press -> 0.
  - Set `lap_hold` 1, then start then clear -> `lap_hold` 0 on entering IDLE.
  - Lap press in PAUSE -> `lap_hold` unchanged.
